// File: rtl/piso_stream.sv
// Parallel-in/serial-out stage: pops words from a first-word-fall-through FIFO and
// streams them as SYM_W-bit symbols with backpressure, frame markers and a one-word prefetch.
module piso_stream #(
    parameter int WORD_W    = 16,
    parameter int SYM_W     = 2,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    output logic [SYM_W-1:0]  data_serial_o,
    output logic              valid_serial_o,
    input  logic              ready_serial_i,
    output logic              first_serial_o,
    output logic              last_serial_o,
    output logic              busy_o
);

    localparam int NSYM  = WORD_W / SYM_W;
    localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSYM - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [WORD_W-1:0] sreg_r, sreg_s;
    logic [WORD_W-1:0] pbuf_r, pbuf_s;
    logic              pbuf_v_r, pbuf_v_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [WORD_W-1:0] shift_s;
    logic              xfer_s;

    // The prefetch slot refills whenever it is empty, so at most one word is outstanding
    assign fifo_rd_en_o = !rst && !fifo_empty_i && !pbuf_v_r;
    assign xfer_s       = (state_r == S_SHIFT) && ready_serial_i;

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign shift_s       = sreg_r >> SYM_W;
            assign data_serial_o = sreg_r[SYM_W-1:0];
        end else begin : g_msb
            assign shift_s       = sreg_r << SYM_W;
            assign data_serial_o = sreg_r[WORD_W-1 -: SYM_W];
        end
    endgenerate

    assign valid_serial_o = (state_r == S_SHIFT);
    assign first_serial_o = (state_r == S_SHIFT) && (cnt_r == CNT_ZERO);
    assign last_serial_o  = (state_r == S_SHIFT) && (cnt_r == CNT_LAST);
    assign busy_o         = (state_r == S_SHIFT) || pbuf_v_r;

    // Next-state logic for the shifter FSM, symbol counter and prefetch buffer
    always_comb begin
        state_s  = state_r;
        sreg_s   = sreg_r;
        cnt_s    = cnt_r;
        pbuf_s   = pbuf_r;
        pbuf_v_s = pbuf_v_r;
        if (fifo_rd_en_o) begin
            pbuf_s   = fifo_data_i;
            pbuf_v_s = 1'b1;
        end else begin
            pbuf_s = pbuf_r;
        end
        case (state_r)
            S_EMPTY: begin
                if (pbuf_v_r) begin
                    sreg_s   = pbuf_r;
                    cnt_s    = CNT_ZERO;
                    pbuf_v_s = 1'b0;
                    state_s  = S_SHIFT;
                end else begin
                    state_s = S_EMPTY;
                end
            end
            S_SHIFT: begin
                if (xfer_s) begin
                    // Loading on the last transfer keeps words back-to-back with no gap
                    if (cnt_r == CNT_LAST) begin
                        if (pbuf_v_r) begin
                            sreg_s   = pbuf_r;
                            cnt_s    = CNT_ZERO;
                            pbuf_v_s = 1'b0;
                            state_s  = S_SHIFT;
                        end else begin
                            state_s = S_EMPTY;
                        end
                    end else begin
                        sreg_s = shift_s;
                        cnt_s  = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = S_SHIFT;
                end
            end
            default: begin
                state_s = S_EMPTY;
            end
        endcase
    end

    // State registers; reset flushes both the partial word and any prefetched word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_EMPTY;
            sreg_r   <= {WORD_W{1'b0}};
            pbuf_r   <= {WORD_W{1'b0}};
            pbuf_v_r <= 1'b0;
            cnt_r    <= CNT_ZERO;
        end else begin
            state_r  <= state_s;
            sreg_r   <= sreg_s;
            pbuf_r   <= pbuf_s;
            pbuf_v_r <= pbuf_v_s;
            cnt_r    <= cnt_s;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: two geometries (16/2 MSB-first, 12/3 LSB-first) checked every
// cycle against a word/index model, plus directed literal expectations.
module tb_piso_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_data = 16'h0;
    logic        a_empty = 1'b1, a_ready = 1'b1, a_rd, a_v, a_f, a_l, a_busy;
    logic [1:0]  a_dout;
    logic [11:0] b_data = 12'h0;
    logic        b_empty = 1'b1, b_ready = 1'b1, b_rd, b_v, b_f, b_l, b_busy;
    logic [2:0]  b_dout;

    piso_stream #(.WORD_W(16), .SYM_W(2), .LSB_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .fifo_data_i(a_data), .fifo_empty_i(a_empty),
        .fifo_rd_en_o(a_rd), .data_serial_o(a_dout), .valid_serial_o(a_v),
        .ready_serial_i(a_ready), .first_serial_o(a_f), .last_serial_o(a_l), .busy_o(a_busy));

    piso_stream #(.WORD_W(12), .SYM_W(3), .LSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .fifo_data_i(b_data), .fifo_empty_i(b_empty),
        .fifo_rd_en_o(b_rd), .data_serial_o(b_dout), .valid_serial_o(b_v),
        .ready_serial_i(b_ready), .first_serial_o(b_f), .last_serial_o(b_l), .busy_o(b_busy));

    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [15:0] qa[$], qb[$];
    logic a_hide = 1'b0, b_hide = 1'b0, a_rd_s = 1'b0, b_rd_s = 1'b0;
    int a_pops = 0, b_pops = 0;
    logic [15:0] a_log[$], b_log[$];
    bit a_log_f[$], a_log_l[$], b_log_l[$];
    int a_log_c[$];

    // Model state per unit: one prefetched word, one word being emitted with its symbol index
    bit          pend_v[2];
    logic [15:0] pend_w[2];
    bit          cur_v[2];
    logic [15:0] cur_w[2];
    int          idx[2];

    function automatic int ns_of(input int u);
        return (u == 0) ? 8 : 4;
    endfunction
    function automatic int sw_of(input int u);
        return (u == 0) ? 2 : 3;
    endfunction
    function automatic logic [15:0] sym_of(input int u, input logic [15:0] w, input int k);
        int sh;
        logic [15:0] m;
        sh = (u != 0) ? sw_of(u) * k : sw_of(u) * (ns_of(u) - 1 - k);
        m  = (16'd1 << sw_of(u)) - 16'd1;
        return (w >> sh) & m;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int u, input logic r, input logic emp, input logic rdy,
                              input logic [15:0] din, input logic rd, input logic v,
                              input logic f, input logic l, input logic bsy,
                              input logic [15:0] dout, output bit xfer);
        string p;
        bit exp_rd;
        p = (u == 0) ? "a" : "b";
        exp_rd = !r && !emp && !pend_v[u];
        chk({p, ".fifo_rd_en"}, {15'h0, rd}, {15'h0, exp_rd});
        chk({p, ".valid"}, {15'h0, v}, {15'h0, cur_v[u]});
        chk({p, ".busy"}, {15'h0, bsy}, {15'h0, cur_v[u] || pend_v[u]});
        if (cur_v[u]) begin
            chk({p, ".data"}, dout, sym_of(u, cur_w[u], idx[u]));
            chk({p, ".first"}, {15'h0, f}, {15'h0, idx[u] == 0});
            chk({p, ".last"}, {15'h0, l}, {15'h0, idx[u] == ns_of(u) - 1});
        end
        xfer = 1'b0;
        if (r) begin
            pend_v[u] = 1'b0;
            cur_v[u]  = 1'b0;
            idx[u]    = 0;
        end else begin
            if (cur_v[u] && rdy) begin
                xfer = 1'b1;
                if (idx[u] == ns_of(u) - 1) cur_v[u] = 1'b0;
                else idx[u] = idx[u] + 1;
            end
            if (!cur_v[u] && pend_v[u]) begin
                cur_w[u]  = pend_w[u];
                cur_v[u]  = 1'b1;
                idx[u]    = 0;
                pend_v[u] = 1'b0;
            end
            if (exp_rd) begin
                pend_w[u] = din;
                pend_v[u] = 1'b1;
            end
        end
    endtask

    // Compare process: check outputs at the falling edge, then advance the model
    initial begin : compare
        bit xa, xb;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            model_step(0, rst, a_empty, a_ready, a_data, a_rd, a_v, a_f, a_l, a_busy,
                       {14'h0, a_dout}, xa);
            model_step(1, rst, b_empty, b_ready, {4'h0, b_data}, b_rd, b_v, b_f, b_l, b_busy,
                       {13'h0, b_dout}, xb);
            if (xa) begin
                a_log.push_back({14'h0, a_dout});
                a_log_f.push_back(a_f);
                a_log_l.push_back(a_l);
                a_log_c.push_back(cyc);
            end
            if (xb) begin
                b_log.push_back({13'h0, b_dout});
                b_log_l.push_back(b_l);
            end
            if (a_rd) a_pops++;
            if (b_rd) b_pops++;
            a_rd_s = a_rd;
            b_rd_s = b_rd;
        end
    end

    // FIFO emulation: pop on the edge after a strobe, present the new head shortly after
    initial begin : fifo_emu
        forever begin
            @(posedge clk);
            if (a_rd_s && qa.size() > 0) void'(qa.pop_front());
            if (b_rd_s && qb.size() > 0) void'(qb.pop_front());
            #2;
            a_empty = (qa.size() == 0) || a_hide;
            a_data  = a_empty ? 16'h0 : qa[0];
            b_empty = (qb.size() == 0) || b_hide;
            b_data  = b_empty ? 12'h0 : qb[0][11:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic sync_n();
        @(negedge clk);
        #1;
    endtask
    task automatic wait_a(input int n);
        int k;
        k = 0;
        while (a_log.size() < n && k < 200) begin
            sync_n();
            k++;
        end
        chk("a.wait_budget", {15'h0, a_log.size() >= n}, 16'h1);
    endtask
    task automatic wait_b(input int n);
        int k;
        k = 0;
        while (b_log.size() < n && k < 200) begin
            sync_n();
            k++;
        end
        chk("b.wait_budget", {15'h0, b_log.size() >= n}, 16'h1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0] exp_a5c3 [8];
        logic [2:0] exp_9a5 [4];
        int p0;
        exp_a5c3 = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
        exp_9a5  = '{3'b101, 3'b100, 3'b110, 3'b100};

        // Reset with data waiting
        rst = 1'b1;
        qa.push_back(16'hA5C3);
        repeat (4) begin
            tick();
            sync_n();
            chk("t1.rd_in_reset", {15'h0, a_rd}, 16'h0);
            chk("t1.valid_in_reset", {15'h0, a_v}, 16'h0);
            chk("t1.data_in_reset", {14'h0, a_dout}, 16'h0);
            chk("t1.busy_in_reset", {15'h0, a_busy}, 16'h0);
        end
        tick();
        rst = 1'b0;
        sync_n();
        chk("t1.first_pop", {15'h0, a_rd}, 16'h1);
        tick();
        sync_n();
        chk("t1.valid_n1", {15'h0, a_v}, 16'h0);
        tick();
        sync_n();
        chk("t1.valid_n2", {15'h0, a_v}, 16'h1);
        chk("t1.first_n2", {15'h0, a_f}, 16'h1);
        chk("t1.data_n2", {14'h0, a_dout}, 16'h2);

        // Single word MSB-first
        wait_a(8);
        tick();
        tick();
        sync_n();
        chk("t2.busy_after", {15'h0, a_busy}, 16'h0);
        chk("t2.pops", a_pops[15:0], 16'h1);
        for (int i = 0; i < 8; i++) begin
            chk("t2.sym", a_log[i], {14'h0, exp_a5c3[i]});
            chk("t2.first", {15'h0, a_log_f[i]}, {15'h0, i == 0});
            chk("t2.last", {15'h0, a_log_l[i]}, {15'h0, i == 7});
        end

        // Back-to-back words
        tick();
        a_log.delete(); a_log_f.delete(); a_log_l.delete(); a_log_c.delete();
        a_pops = 0;
        qa.push_back(16'hAAAA); qa.push_back(16'h5555); qa.push_back(16'hFFFF);
        wait_a(24);
        for (int i = 0; i < 24; i++)
            chk("t3.sym", a_log[i], (i < 8) ? 16'h2 : (i < 16) ? 16'h1 : 16'h3);
        chk("t3.no_gap", 16'(a_log_c[23] - a_log_c[0]), 16'd23);
        tick();
        tick();
        sync_n();
        chk("t3.pops", a_pops[15:0], 16'h3);

        // Backpressure while symbol 3 is presented
        tick();
        a_log.delete(); a_log_f.delete(); a_log_l.delete(); a_log_c.delete();
        qa.push_back(16'hA5C3);
        wait_a(3);
        tick();
        a_ready = 1'b0;
        qa.push_back(16'h1234);
        p0 = a_pops;
        repeat (4) begin
            sync_n();
            chk("t4.stall_data", {14'h0, a_dout}, 16'h1);
            chk("t4.stall_valid", {15'h0, a_v}, 16'h1);
        end
        chk("t4.stall_pops", 16'(a_pops - p0), 16'h1);
        tick();
        a_ready = 1'b1;
        wait_a(16);
        for (int i = 0; i < 8; i++) chk("t4.sym", a_log[i], {14'h0, exp_a5c3[i]});

        // LSB-first 12/3 geometry
        tick();
        b_log.delete(); b_log_l.delete();
        qb.push_back(16'h09A5);
        wait_b(4);
        for (int i = 0; i < 4; i++) begin
            chk("t5.sym", b_log[i], {13'h0, exp_9a5[i]});
            chk("t5.last", {15'h0, b_log_l[i]}, {15'h0, i == 3});
        end

        // Reset mid-word with a prefetched word
        tick();
        a_log.delete(); a_log_f.delete(); a_log_l.delete(); a_log_c.delete();
        a_pops = 0;
        qa.push_back(16'hA5C3); qa.push_back(16'h1234);
        wait_a(4);
        tick();
        rst = 1'b1;
        qa.push_back(16'h0F0F);
        sync_n();
        chk("t6.valid_sym4", {15'h0, a_v}, 16'h1);
        chk("t6.prefetched", a_pops[15:0], 16'h2);
        tick();
        rst = 1'b0;
        a_log.delete(); a_log_f.delete(); a_log_l.delete(); a_log_c.delete();
        sync_n();
        chk("t6.valid_after_rst", {15'h0, a_v}, 16'h0);
        chk("t6.busy_after_rst", {15'h0, a_busy}, 16'h0);
        wait_a(8);
        for (int i = 0; i < 8; i++)
            chk("t6.sym", a_log[i], ((i % 4) < 2) ? 16'h0 : 16'h3);
        chk("t6.first", {15'h0, a_log_f[0]}, 16'h1);

        // Randomized traffic, gaps, backpressure and occasional resets
        for (int i = 0; i < 1500; i++) begin
            tick();
            rst     = ($urandom_range(0, 299) == 0);
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
            a_hide  = ($urandom_range(0, 3) == 0);
            b_hide  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0 && qa.size() < 4) qa.push_back(16'($urandom));
            if ($urandom_range(0, 2) == 0 && qb.size() < 4) qb.push_back({4'h0, 12'($urandom)});
        end
        tick();
        rst = 1'b0; a_ready = 1'b1; b_ready = 1'b1; a_hide = 1'b0; b_hide = 1'b0;
        repeat (60) tick();
        sync_n();
        chk("end.a_busy", {15'h0, a_busy}, 16'h0);
        chk("end.b_busy", {15'h0, b_busy}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
